// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one Q8.8 sign-magnitude multiplier.
// Define MULT_PIPE_EN to add a PIPE state that re-registers operands.

module mult (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  // Unsigned product of the zero-extended magnitudes
  always_comb p_o = {16'b0, a_i} * {16'b0, b_i};

endmodule

module mult_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_op_a,
  input  logic [16*NUM_REQ-1:0]   req_op_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [15:0]             rsp_result,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

`ifdef MULT_PIPE_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    PIPE = 2'd2,
    RESP = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd3
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       b_q, b_d;
  logic [15:0]       res_q, res_d;
  logic [15:0]       a_sel, b_sel;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [15:0]       src_a, src_b;
  logic [15:0]       m_a, m_b;
  logic [31:0]       prod;
  logic              sign;
  logic              unused_prod;

`ifdef MULT_PIPE_EN
  logic [15:0]       pa_q, pa_d;
  logic [15:0]       pb_q, pb_d;

  assign src_a = pa_q;
  assign src_b = pb_q;
`else
  assign src_a = a_q;
  assign src_b = b_q;
`endif

  assign m_a  = {1'b0, src_a[14:0]};
  assign m_b  = {1'b0, src_b[14:0]};
  assign sign = src_a[15] ^ src_b[15];

  mult u_mult (
    .a_i (m_a),
    .b_i (m_b),
    .p_o (prod)
  );

  assign unused_prod = ^{prod[31:23], prod[7:0]};

  // First valid requester at or after rr_ptr_q, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  // Operands of the winning requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == ID_W'(j)) begin
        a_sel = req_op_a[16*j +: 16];
        b_sel = req_op_b[16*j +: 16];
      end
    end
  end

  // Next state and datapath register updates
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
`ifdef MULT_PIPE_EN
    pa_d     = pa_q;
    pb_d     = pb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          a_d      = a_sel;
          b_d      = b_sel;
          grant_d  = win;
          rr_ptr_d = (win == ID_W'(NUM_REQ-1))
                     ? '0 : win + 1'b1;
          state_d  = CALC;
        end
      end
`ifdef MULT_PIPE_EN
      CALC: begin
        pa_d    = a_q;
        pb_d    = b_q;
        state_d = PIPE;
      end
      PIPE: begin
        res_d   = {sign, prod[22:8]};
        state_d = RESP;
      end
`else
      CALC: begin
        res_d   = {sign, prod[22:8]};
        state_d = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready[grant_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
`ifdef MULT_PIPE_EN
      pa_q     <= '0;
      pb_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
`ifdef MULT_PIPE_EN
      pa_q     <= pa_d;
      pb_q     <= pb_d;
`endif
    end
  end

  // One-hot ready in IDLE, one-hot valid in RESP
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = rst_n & found
                   & (state_q == IDLE)
                   & (win == ID_W'(j));
      rsp_valid[j] = (state_q == RESP)
                   & (grant_q == ID_W'(j));
    end
  end

  assign busy       = (state_q != IDLE);
  assign rsp_result = res_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table, corner sequences and random rounds.
// Honours MULT_PIPE_EN for the expected latency.

module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef MULT_PIPE_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] op_a = '0;
  logic [16*N-1:0] op_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '1;
  logic [15:0]     rsp_result;
  logic            busy;
  logic [IDW-1:0]  grant_id;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ra [N];
  logic [15:0] rb [N];

  always #5 clk = ~clk;

  mult_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (op_a),
    .req_op_b   (op_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned ma, mb, m;
    ma = int'(a & 16'h7fff);
    mb = int'(b & 16'h7fff);
    m  = ((ma * mb) / 256) % 32768;
    return {a[15] ^ b[15], m[14:0]};
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    op_a[16*i +: 16] = a;
    op_b[16*i +: 16] = b;
    ra[i] = a;
    rb[i] = b;
  endtask

  task automatic wait_rsp(input string nm, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no rsp_valid, want one", nm);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_one(input string nm, input int id,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
    req_valid = oh(id);
    rsp_ready = '1;
    set_op(id, a, b);
    #1;
    chk({nm, "_rdy"}, req_ready, oh(id));
    chk({nm, "_idle"}, busy, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk({nm, "_early"}, rsp_valid, 0);
    chk({nm, "_busy"}, busy, 1);
    repeat (D - 1) begin
      @(negedge clk);
      chk({nm, "_early2"}, rsp_valid, 0);
    end
    @(negedge clk);
    chk({nm, "_vld"}, rsp_valid, oh(id));
    chk({nm, "_res"}, rsp_result, exp);
    chk({nm, "_gid"}, grant_id, id);
    @(negedge clk);
    chk({nm, "_done"}, rsp_valid, 0);
    chk({nm, "_free"}, busy, 0);
  endtask

  initial begin
    vec_t tbl [8];
    bit ok;
    int rr, w, d;
    logic [N-1:0] mask;

    tbl[0] = '{16'h0180, 16'h0200, 16'h0300};
    tbl[1] = '{16'h8100, 16'h0280, 16'h8280};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7F00};
    tbl[3] = '{16'h8000, 16'h0100, 16'h8000};
    tbl[4] = '{16'h8001, 16'h8001, 16'h0000};
    tbl[5] = '{16'hFFFF, 16'h0100, 16'hFFFF};
    tbl[6] = '{16'h0080, 16'h0080, 16'h0040};
    tbl[7] = '{16'h8300, 16'h8040, 16'h00C0};

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_res", rsp_result, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_one($sformatf("vec%0d", i), i % N,
              tbl[i].a, tbl[i].b, tbl[i].exp);

    // round-robin with every requester held valid
    do_reset();
    for (int i = 0; i < N; i++)
      set_op(i, 16'h0100 + 16'(i * 16'h0040),
             16'h0200 + 16'(i * 16'h0180));
    rsp_ready = '1;
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("rr%0d_rdy", g), req_ready, oh(g % N));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_gid", g), grant_id, g % N);
      wait_rsp("rr", ok);
      chk($sformatf("rr%0d_res", g), rsp_result,
          model(ra[g % N], rb[g % N]));
      @(negedge clk);
    end
    req_valid = '0;

    // response stall on requester 1
    req_valid = oh(1);
    rsp_ready = '0;
    set_op(1, 16'h0300, 16'h0040);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1101;
    wait_rsp("stall", ok);
    chk("stall_vld", rsp_valid, 4'b0010);
    chk("stall_res", rsp_result, 16'h00C0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_vld", c), rsp_valid, 4'b0010);
      chk($sformatf("stall%0d_res", c), rsp_result, 16'h00C0);
      chk($sformatf("stall%0d_rdy", c), req_ready, 0);
    end
    rsp_ready = 4'b1101;
    @(negedge clk);
    chk("stall_other_rdy", rsp_valid, 4'b0010);
    rsp_ready = 4'b0010;
    #1;
    chk("exit_no_grant", req_ready, 0);
    @(negedge clk);
    chk("exit_vld", rsp_valid, 0);
    chk("exit_next_rr", req_ready, 4'b0100);
    req_valid = '0;
    rsp_ready = '1;

    // reset in the middle of a transaction
    req_valid = oh(2);
    set_op(2, 16'h0180, 16'h0200);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1100;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_vld", rsp_valid, 0);
    chk("mrst_rdy", req_ready, 0);
    chk("mrst_gid", grant_id, 0);
    chk("mrst_res", rsp_result, 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mrst%0d_quiet", c), rsp_valid, 0);
      chk($sformatf("mrst%0d_idle", c), busy, 0);
    end
    set_op(2, 16'h0500, 16'h8080);
    set_op(3, 16'h0100, 16'h0100);
    req_valid = 4'b1100;
    #1;
    chk("mrst_rr0", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("mrst", ok);
    chk("mrst_gid2", grant_id, 2);
    chk("mrst_res2", rsp_result, 16'h8280);
    @(negedge clk);

    // random rounds against the round-robin model
    do_reset();
    rr = 0;
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        set_op(i, 16'($urandom), 16'($urandom));
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && mask[(rr + k) % N])
          w = (rr + k) % N;
      req_valid = mask;
      rsp_ready = '1;
      #1;
      chk($sformatf("rnd%0d_rdy", r), req_ready, oh(w));
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      rsp_ready = '0;
      d = $urandom_range(0, 3);
      wait_rsp("rnd", ok);
      chk($sformatf("rnd%0d_vld", r), rsp_valid, oh(w));
      chk($sformatf("rnd%0d_res", r), rsp_result, model(ra[w], rb[w]));
      chk($sformatf("rnd%0d_gid", r), grant_id, w);
      repeat (d) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_hold", r), rsp_valid, oh(w));
      end
      rsp_ready = oh(w) | N'($urandom);
      @(negedge clk);
      chk($sformatf("rnd%0d_done", r), rsp_valid, 0);
      rr = (w + 1) % N;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

endmodule
